if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS core. It sits directly upstream of the instruction memory.
- Holds the PC and drives the memory's chip-enable and byte address, then registers the returned word into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect, exception/ERET redirect with flush, delay-slot tagging and fetch-alignment exceptions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; first instruction fetched.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge)
stall  in  1  hazard stall from ID; holds PC and IF/ID
br_taken  in  1  branch/jump resolved taken in ID
br_target  in  32  redirect target from ID
id_is_branch  in  1  instruction currently in ID is a branch/jump
excp_valid  in  1  exception/ERET redirect from EX/MEM
excp_pc  in  32  handler or EPC target
inst_data  in  32  word from instruction memory (combinational, same cycle)
inst_ce  out  1  instruction memory chip-enable
inst_addr  out  32  byte address to instruction memory (= pc)
id_pc  out  32  PC of instruction in ID
id_inst  out  32  instruction word in ID
id_valid  out  1  ID slot holds a real fetch
id_delay_slot  out  1  ID instruction sits in a branch delay slot
id_adel  out  1  fetch address misaligned (AdEL); id_inst forced 0

Behaviour:
- Reset (rst==0 at edge):
  - Internal ce_r=0, pc=RESET_PC.
  - id_pc=0, id_inst=0, id_valid=0, id_delay_slot=0, id_adel=0.
  - Reset mid-operation discards all state at that edge.
- Enable:
  - ce_r<=1 on every edge with rst==1.
  - While ce_r==0, pc stays RESET_PC. The first fetch is of RESET_PC in the first cycle where ce_r==1.
- Memory interface:
  - inst_addr=pc.
  - inst_ce=ce_r & (pc[1:0]==2'b00).
  - Fetch latency is zero; inst_data is sampled at the same edge that advances the PC.
- Next-PC priority, applied only when ce_r==1:
  1. excp_valid: pc<=excp_pc. Applied regardless of stall.
  2. stall: pc holds.
  3. br_taken: pc<=br_target.
  4. Otherwise pc<=pc+4. Modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Delay slot:
  - The instruction fetched in the cycle br_taken is asserted is the delay slot. It is never flushed by a branch.
  - br_taken while stall==1 is ignored; ID re-presents it once the stall clears.
- IF/ID register, on each edge with rst==1:
  - excp_valid: flush. id_valid=0, id_inst=0, id_pc=0, id_delay_slot=0, id_adel=0.
  - Else stall: all id_* hold.
  - Else ce_r==0: load a bubble (id_valid=0, id_inst=0).
  - Else advance:
    - id_pc<=pc
    - id_inst<=aligned ? inst_data : 0
    - id_valid<=1
    - id_adel<=~aligned
    - id_delay_slot<=id_is_branch & id_valid
- Misaligned PC (pc[1:0]!=0):
  - Memory is not enabled; a NOP is passed with id_adel=1.
  - PC still advances by +4 until an exception redirect arrives. ID/EX is responsible for raising the exception.
- Simultaneous events:
  - excp_valid overrides both stall and br_taken in the same cycle.
  - stall overrides br_taken.
- No combinational path exists from any input to any id_* output. inst_addr and inst_ce depend on registers only.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then 1, with memory word0=0x0000f025 and word1=0x241d1000.
  -> Cycle 1: inst_ce=0, id_valid=0.
  -> Cycle 2: inst_addr=0x0, inst_ce=1.
  -> Next edge: id_inst=0x0000f025, id_pc=0x0.
  -> Following edge: id_pc=0x4, id_inst=0x241d1000.
- Stall: assert stall for 2 cycles while pc=0x10.
  -> inst_addr stays 0x10; id_pc/id_inst unchanged.
  -> After release, pc goes 0x14 then 0x18.
- Branch with delay slot: ID holds a branch at 0x2C (id_is_branch=1), br_taken=1, br_target=0x00, pc=0x30.
  -> id_pc=0x30 with id_delay_slot=1.
  -> Next fetch address is 0x00.
- Exception flush while stalled: stall=1, excp_valid=1, excp_pc=0x80 in the same cycle.
  -> id_valid=0, id_inst=0.
  -> pc=0x80 on the next cycle.
- Misaligned redirect: br_target=0x0000_0042.
  -> inst_ce=0 while pc=0x42.
  -> id_adel=1, id_inst=0, id_pc=0x42.
- Wrap and mid-run reset:
  -> With excp_pc=0xFFFF_FFFC, the next pc is 0x0000_0000.
  -> Pulsing rst=0 mid-fetch gives id_valid=0 and pc=RESET_PC after that edge.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory port plus the ID-side control
// inputs and the IF/ID register outputs of the fetch stage.
interface if_stage_if;
   // Control from downstream stages
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        id_is_branch;
   logic        excp_valid;
   logic [31:0] excp_pc;
   // Instruction memory port (zero-latency read)
   logic [31:0] inst_data;
   logic        inst_ce;
   logic [31:0] inst_addr;
   // IF/ID pipeline register
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_delay_slot;
   logic        id_adel;

   // Fetch stage side
   modport master (
      input  stall, br_taken, br_target, id_is_branch, excp_valid, excp_pc,
      input  inst_data,
      output inst_ce, inst_addr,
      output id_pc, id_inst, id_valid, id_delay_slot, id_adel
   );

   // Memory / decode / control side
   modport slave (
      output stall, br_taken, br_target, id_is_branch, excp_valid, excp_pc,
      output inst_data,
      input  inst_ce, inst_addr,
      input  id_pc, id_inst, id_valid, id_delay_slot, id_adel
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// captures the fetched word into the IF/ID register. Redirect priority is
// exception > stall > branch > sequential. There are no valid/ready
// handshakes here: stall is a level hold, and redirects take effect on the
// edge at which they are sampled.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     rst,
   if_stage_if.master bus
);

   logic        ce_r;
   logic [31:0] pc;
   logic        aligned;

   assign aligned       = (pc[1:0] == 2'b00);
   assign bus.inst_addr = pc;
   // A misaligned PC never reaches memory; a NOP with AdEL goes down instead.
   assign bus.inst_ce   = ce_r & aligned;

   // Fetch enable comes up one cycle after reset release.
   always_ff @(posedge clk) begin
      if (!rst) ce_r <= 1'b0;
      else      ce_r <= 1'b1;
   end

   // Next-PC selection; the PC is frozen at RESET_PC until fetch is enabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (ce_r) begin
         if (bus.excp_valid)    pc <= bus.excp_pc;
         else if (bus.stall)    pc <= pc;
         else if (bus.br_taken) pc <= bus.br_target;
         else                   pc <= pc + 32'd4;
      end
   end

   // IF/ID register: flush on exception, hold on stall, bubble before enable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.id_pc         <= 32'h0;
         bus.id_inst       <= 32'h0;
         bus.id_valid      <= 1'b0;
         bus.id_delay_slot <= 1'b0;
         bus.id_adel       <= 1'b0;
      end else if (bus.excp_valid) begin
         bus.id_pc         <= 32'h0;
         bus.id_inst       <= 32'h0;
         bus.id_valid      <= 1'b0;
         bus.id_delay_slot <= 1'b0;
         bus.id_adel       <= 1'b0;
      end else if (bus.stall) begin
         bus.id_pc         <= bus.id_pc;
         bus.id_inst       <= bus.id_inst;
         bus.id_valid      <= bus.id_valid;
         bus.id_delay_slot <= bus.id_delay_slot;
         bus.id_adel       <= bus.id_adel;
      end else if (!ce_r) begin
         bus.id_inst       <= 32'h0;
         bus.id_valid      <= 1'b0;
      end else begin
         bus.id_pc         <= pc;
         bus.id_inst       <= aligned ? bus.inst_data : 32'h0;
         bus.id_valid      <= 1'b1;
         bus.id_adel       <= ~aligned;
         // Whatever follows a real branch in ID is its delay slot.
         bus.id_delay_slot <= bus.id_is_branch & bus.id_valid;
      end
   end

endmodule
